counter_x: RTL and testbench
============================

COUNTER_X -- requirements
Module: counter_x

Interface
REQ-001 Clock and reset SHALL be one clock and one reset. clk is the single clock. rst is a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 tick0, tick1, tick2  input  1 each  per-channel count-enable strobes, one clk wide, from the clock dividers.
REQ-005 counter_we  input  1  write strobe, driven by the bus decoder for the counter address.
REQ-006 counter_val  input  32  write data (Peripheral_in).
REQ-007 counter_ch  input  2  target select, latched from a GPIO register. 00/01/10 select channels 0/1/2; 11 selects the control register.
REQ-008 counter0_out, counter1_out, counter2_out  output  1 each  registered channel outputs.
REQ-009 counter_out  output  32  readback of the target chosen by counter_ch.

Function
REQ-010 Each channel SHALL hold a 32-bit load register LOADn, a 32-bit down-counter CNTn, an output bit OUTn and an armed flag ARMn.
REQ-011 The control register CTRL SHALL be 11 bits:
- [1:0] mode of ch0; [3:2] mode of ch1; [5:4] mode of ch2.
- [8], [9], [10] gate of ch0, ch1, ch2.
- Other bits of counter_val are ignored on a CTRL write.
REQ-012 Mode encodings SHALL be: 00 one-shot; 01 periodic pulse; 10 square wave; 11 hold (CNTn frozen, OUTn unchanged).
REQ-013 A write with counter_we=1 and counter_ch=n (n<3) SHALL set LOADn=CNTn=counter_val, OUTn=0 and ARMn=1 on that edge.
REQ-014 A write with counter_ch=11 SHALL update CTRL. Any channel whose mode field changes SHALL have OUTn cleared on the same edge; CNTn and LOADn are unchanged.
REQ-015 A channel SHALL count only on a cycle where tickn=1, its gate bit=1, ARMn=1 and mode!=11. All other cycles hold its state.
REQ-016 One-shot mode, per counting cycle:
- If CNTn>1: CNTn decrements.
- If CNTn==1: CNTn becomes 0, OUTn=1 and ARMn=0.
- OUTn then stays 1 until the next write to that channel.
REQ-017 Periodic mode, per counting cycle:
- If CNTn>1: CNTn decrements.
- If CNTn==1: CNTn reloads from LOADn and OUTn=1 for exactly one clk cycle.
- OUTn returns to 0 on the next edge regardless of tick.
REQ-018 Square-wave mode, per counting cycle:
- If CNTn>1: CNTn decrements.
- If CNTn==1: CNTn reloads from LOADn and OUTn toggles.
- The output period is therefore 2*LOADn ticks.
REQ-019 Load value 0 SHALL disable counting in every mode: the channel sets ARMn=0 and OUTn stays 0. Load value 1 in periodic mode SHALL pulse on every counting cycle.
REQ-020 When a write to channel n and a counting cycle of channel n coincide, the write SHALL win and the tick is discarded. Other channels count normally in that cycle.
REQ-021 Channels SHALL be fully independent. Simultaneous events on multiple channels are all processed in the same cycle.
REQ-022 counter_out SHALL be combinational from registered state:
- CNTn when counter_ch=n.
- {21'b0, CTRL} when counter_ch=11.
- A read reflects writes from the previous edge (zero-cycle read latency, one-cycle write-to-read latency).
REQ-023 counterN_out SHALL be driven directly from OUTn registers; there is no combinational path from any input.
REQ-024 Wrap-around: CNTn SHALL never decrement below 0. The 32-bit arithmetic is unsigned with no overflow path.

Reset
REQ-025 On rst=1 at a clk edge, the block SHALL set:
- LOADn=0, CNTn=0, OUTn=0, ARMn=0 for all three channels.
- CTRL=0, so all gates are off and all modes are one-shot.
REQ-026 rst SHALL take priority over counter_we and ticks in the same cycle. Asserting rst mid-count SHALL abort all channels without any output pulse.

Verification
REQ-027 One-shot on ch0: CTRL=0x100, write ch0=5, tick0 every cycle -> counter0_out rises on the 5th tick edge; CNT0 reads 0; no further change with more ticks.
REQ-028 Periodic on ch1: CTRL=0x204, write ch1=3, tick1 every 4 clks -> counter1_out is a one-clk pulse every 12 clks; CNT1 cycles 3,2,1,3.
REQ-029 Square wave on ch2: CTRL=0x420, write ch2=4, tick2 continuous -> counter2_out toggles every 4 clks (period 8); gate dropped mid-count freezes CNT2 and counter2_out.
REQ-030 Collision on ch0: write ch0=10 in the same cycle as a tick0 that would expire the count -> CNT0=10, counter0_out=0, no expiry event.
REQ-031 Zero load and reset: write ch1=0 in periodic mode -> no pulses over 100 ticks. Separately, assert rst during an active square wave -> all outputs 0, counter_out=0 for every counter_ch value, CTRL readback 0.
REQ-032 Mode change: switching ch0 from one-shot (OUT0=1) to periodic via a CTRL write -> OUT0 clears on that edge; CNT0 is unchanged.

Source files
------------

// File: rtl/counter_x.sv
// Three-channel programmable down-counter/timer with a shared control register.
// Channels run in one-shot, periodic-pulse, square-wave or hold mode, gated per channel.
module counter_x (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick0,
    input  logic        tick1,
    input  logic        tick2,
    input  logic        counter_we,
    input  logic [31:0] counter_val,
    input  logic [1:0]  counter_ch,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out,
    output logic [31:0] counter_out
);

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam logic [1:0] CH_CTRL = 2'b11;

    logic [10:0] ctrl_q;
    logic        ctrl_we;
    logic [2:0]  tick;
    logic [2:0]  out_vec;
    logic [31:0] cnt_vec [3];

    assign tick    = {tick2, tick1, tick0};
    assign ctrl_we = counter_we && (counter_ch == CH_CTRL);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // pre-edge values and the order of statements across blocks is irrelevant.
        if (rst) begin
            ctrl_q <= '0;
        end else if (ctrl_we) begin
            ctrl_q <= counter_val[10:0];
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [31:0] load_q, load_d;
        logic [31:0] cnt_q, cnt_d;
        logic        out_q, out_d;
        logic        arm_q, arm_d;
        mode_e       mode;
        logic        counting;
        logic        wr;
        logic        mode_chg;

        assign mode     = mode_e'(ctrl_q[2*i +: 2]);
        assign wr       = counter_we && (counter_ch == 2'(i));
        assign mode_chg = ctrl_we && (counter_val[2*i +: 2] != ctrl_q[2*i +: 2]);
        assign counting = tick[i] && ctrl_q[8+i] && arm_q && (mode != MODE_HOLD);

        always_comb begin
            // NOTE: every next-state signal gets a default first, so no path
            // through this block can leave one unassigned and infer a latch.
            load_d = load_q;
            cnt_d  = cnt_q;
            out_d  = out_q;
            arm_d  = arm_q;

            // A periodic pulse lasts exactly one clk, tick or not.
            if (mode == MODE_PERIODIC) begin
                out_d = 1'b0;
            end

            if (counting) begin
                if (cnt_q > 32'd1) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (cnt_q == 32'd1) begin
                    case (mode)
                        MODE_ONESHOT: begin
                            cnt_d = '0;
                            out_d = 1'b1;
                            arm_d = 1'b0;
                        end
                        MODE_PERIODIC: begin
                            cnt_d = load_q;
                            out_d = 1'b1;
                        end
                        MODE_SQUARE: begin
                            cnt_d = load_q;
                            out_d = ~out_q;
                        end
                        default: ;
                    endcase
                end else begin
                    // Never decrement below zero; an empty counter disarms.
                    arm_d = 1'b0;
                end
            end

            if (mode_chg) begin
                out_d = 1'b0;
            end

            // A channel write overrides any tick landing on the same edge.
            if (wr) begin
                load_d = counter_val;
                cnt_d  = counter_val;
                out_d  = 1'b0;
                arm_d  = |counter_val;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: these registers hold architectural state that software reads
            // back, so they are reset explicitly rather than left undefined.
            if (rst) begin
                load_q <= '0;
                cnt_q  <= '0;
                out_q  <= 1'b0;
                arm_q  <= 1'b0;
            end else begin
                load_q <= load_d;
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                arm_q  <= arm_d;
            end
        end

        assign cnt_vec[i] = cnt_q;
        assign out_vec[i] = out_q;
    end

    assign counter0_out = out_vec[0];
    assign counter1_out = out_vec[1];
    assign counter2_out = out_vec[2];

    always_comb begin
        counter_out = '0;
        case (counter_ch)
            2'b00:   counter_out = cnt_vec[0];
            2'b01:   counter_out = cnt_vec[1];
            2'b10:   counter_out = cnt_vec[2];
            default: counter_out = {21'b0, ctrl_q};
        endcase
    end

endmodule

// File: tb/tb_counter_x.sv
// Scoreboard bench for counter_x: stimulus queues expected readback/outputs,
// a negedge monitor pops and compares them.
module tb_counter_x;

    logic        clk;
    logic        rst;
    logic        tick0, tick1, tick2;
    logic        counter_we;
    logic [31:0] counter_val;
    logic [1:0]  counter_ch;
    logic        counter0_out, counter1_out, counter2_out;
    logic [31:0] counter_out;

    counter_x dut (
        .clk          (clk),
        .rst          (rst),
        .tick0        (tick0),
        .tick1        (tick1),
        .tick2        (tick2),
        .counter_we   (counter_we),
        .counter_val  (counter_val),
        .counter_ch   (counter_ch),
        .counter0_out (counter0_out),
        .counter1_out (counter1_out),
        .counter2_out (counter2_out),
        .counter_out  (counter_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    logic        obs_valid = 1'b0;
    logic [34:0] exp_q [$];
    string       name_q [$];

    // Periodic ch1, load 3, tick every 4 clks: CNT1 seen before each edge.
    int per_cnt [25] = '{3,2,2,2,2,1,1,1,1,3,3,3,3,2,2,2,2,1,1,1,1,3,3,3,3};
    // Square ch2, load 4, continuous tick.
    int sq_cnt  [6]  = '{4,3,2,1,4,3};
    int sq_out  [6]  = '{0,0,0,0,1,1};

    task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: counter_out=0x%08h outs(2:0)=%b, expected counter_out=0x%08h outs(2:0)=%b",
                     name, got[34:3], got[2:0], exp[34:3], exp[2:0]);
        end
    endtask

    // Monitor: compares whatever the DUT presents on a cycle the stimulus marked.
    initial begin
        logic [34:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (obs_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: observation with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, {counter_out, counter2_out, counter1_out, counter0_out}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        obs_valid = 1'b0;
    endtask

    task automatic write(input logic [1:0] ch, input logic [31:0] val);
        counter_ch  = ch;
        counter_val = val;
        counter_we  = 1'b1;
        step();
        counter_we  = 1'b0;
    endtask

    // Queue an expectation for the current cycle, then advance one clk.
    task automatic obs(input string name, input logic [1:0] ch, input logic [31:0] val,
                       input logic [2:0] outs);
        counter_ch = ch;
        name_q.push_back(name);
        exp_q.push_back({val, outs});
        obs_valid = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1;
        tick0 = 1'b0; tick1 = 1'b0; tick2 = 1'b0;
        counter_we = 1'b0; counter_val = '0; counter_ch = 2'b00;
        step();
        step();
        rst = 1'b0;

        obs("reset_ctrl", 2'b11, 32'h0, 3'b000);
        obs("reset_cnt0", 2'b00, 32'h0, 3'b000);

        // One-shot ch0, load 5.
        write(2'b11, 32'h100);
        write(2'b00, 32'd5);
        tick0 = 1'b1;
        obs("oneshot_cnt5", 2'b00, 32'd5, 3'b000);
        obs("oneshot_cnt4", 2'b00, 32'd4, 3'b000);
        obs("oneshot_cnt3", 2'b00, 32'd3, 3'b000);
        obs("oneshot_cnt2", 2'b00, 32'd2, 3'b000);
        obs("oneshot_cnt1", 2'b00, 32'd1, 3'b000);
        obs("oneshot_fired", 2'b00, 32'd0, 3'b001);
        obs("oneshot_stays", 2'b00, 32'd0, 3'b001);
        tick0 = 1'b0;

        // Mode change clears OUT0, keeps CNT0.
        write(2'b11, 32'h101);
        obs("modechg_out0", 2'b00, 32'd0, 3'b000);
        obs("modechg_ctrl", 2'b11, 32'h101, 3'b000);

        // Periodic ch1, load 3, tick1 every 4 clks.
        write(2'b11, 32'h204);
        write(2'b01, 32'd3);
        for (int k = 0; k < 25; k++) begin
            tick1 = (k % 4 == 0);
            obs($sformatf("periodic_k%0d", k), 2'b01, 32'(per_cnt[k]),
                (k == 9 || k == 21) ? 3'b010 : 3'b000);
        end
        tick1 = 1'b0;

        // Square wave ch2, load 4, then gate dropped while OUT2=1.
        write(2'b11, 32'h420);
        write(2'b10, 32'd4);
        tick2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            obs($sformatf("square_k%0d", k), 2'b10, 32'(sq_cnt[k]), sq_out[k] != 0 ? 3'b100 : 3'b000);
        end
        write(2'b11, 32'h020);
        obs("gate_freeze_a", 2'b10, 32'd1, 3'b100);
        obs("gate_freeze_b", 2'b10, 32'd1, 3'b100);
        obs("gate_freeze_c", 2'b10, 32'd1, 3'b100);
        tick2 = 1'b0;

        // Write colliding with the expiring tick on ch0.
        write(2'b11, 32'h120);
        write(2'b00, 32'd2);
        tick0 = 1'b1;
        obs("collide_pre", 2'b00, 32'd2, 3'b100);
        counter_ch  = 2'b00;
        counter_val = 32'd10;
        counter_we  = 1'b1;
        step();
        counter_we  = 1'b0;
        tick0 = 1'b0;
        obs("collide_cnt", 2'b00, 32'd10, 3'b100);
        obs("collide_hold", 2'b00, 32'd10, 3'b100);
        tick0 = 1'b1;
        obs("collide_resume", 2'b00, 32'd10, 3'b100);
        tick0 = 1'b0;
        obs("collide_cnt9", 2'b00, 32'd9, 3'b100);

        // Zero load in periodic mode never pulses.
        write(2'b11, 32'h324);
        obs("zero_ctrl", 2'b11, 32'h324, 3'b100);
        write(2'b01, 32'd0);
        tick1 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            obs($sformatf("zero_load_k%0d", k), 2'b01, 32'd0, 3'b100);
        end

        // Load 1 in periodic mode pulses on every counting cycle.
        write(2'b01, 32'd1);
        obs("load1_a", 2'b01, 32'd1, 3'b100);
        obs("load1_b", 2'b01, 32'd1, 3'b110);
        obs("load1_c", 2'b01, 32'd1, 3'b110);
        tick1 = 1'b0;
        obs("load1_d", 2'b01, 32'd1, 3'b110);
        obs("load1_end", 2'b01, 32'd1, 3'b100);

        // Reset in the middle of an active square wave.
        write(2'b11, 32'h420);
        write(2'b10, 32'd2);
        tick2 = 1'b1;
        obs("sq2_a", 2'b10, 32'd2, 3'b000);
        obs("sq2_b", 2'b10, 32'd1, 3'b000);
        obs("sq2_c", 2'b10, 32'd2, 3'b100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tick2 = 1'b0;
        obs("rst_cnt0", 2'b00, 32'd0, 3'b000);
        obs("rst_cnt1", 2'b01, 32'd0, 3'b000);
        obs("rst_cnt2", 2'b10, 32'd0, 3'b000);
        obs("rst_ctrl", 2'b11, 32'd0, 3'b000);

        step();
        step();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations never observed, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
